// File: rtl/spawn_scheduler.sv
// spawn_scheduler
//
// Collects per-column spawn requests between beat ticks and, on each tick
// while the song is running, grants up to MAX_PER_TICK of them in
// round-robin order. A granted column is then blocked for MIN_GAP ticks.
// The block also drives the shared difficulty level, which starts at
// DIFF_INIT when a game begins and rises by one every RAMP_TICKS ticks,
// saturating at 7.
//
// Ports:
//   clk          in   system clock, all logic on posedge
//   reset        in   synchronous, active-low (0 = reset)
//   game_en      in   level, 1 = song playing
//   tick         in   one-cycle beat strobe
//   spawn_req    in   [NUM_COLS] request pulses from the column deciders
//   spawn_out    out  [NUM_COLS] registered grant pulses to the light shifters
//   diff_setting out  [3] difficulty fed to every column decider
//   running      out  1 while the FSM is in RUN
module spawn_scheduler #(
    parameter int NUM_COLS     = 4,
    parameter int MAX_PER_TICK = 2,
    parameter int MIN_GAP      = 2,
    parameter int RAMP_TICKS   = 64,
    parameter int DIFF_INIT    = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                game_en,
    input  logic                tick,
    input  logic [NUM_COLS-1:0] spawn_req,
    output logic [NUM_COLS-1:0] spawn_out,
    output logic [2:0]          diff_setting,
    output logic                running
);

    localparam int RR_W  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int CD_W  = $clog2(MIN_GAP + 1);
    localparam int CNT_W = $clog2(RAMP_TICKS);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_COLS-1:0] pending_q, pending_d;
    logic [CD_W-1:0]     cd_q [NUM_COLS];
    logic [CD_W-1:0]     cd_d [NUM_COLS];
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RR_W-1:0]     rr_q, rr_d;
    logic [2:0]          diff_q, diff_d;
    logic [NUM_COLS-1:0] spawn_q, spawn_d;

    logic [NUM_COLS-1:0] req_all;
    logic [NUM_COLS-1:0] eligible;
    logic [NUM_COLS-1:0] grant;
    int                  n_grant;
    int                  last_idx;
    int                  idx;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        cd_d      = cd_q;
        cnt_d     = cnt_q;
        rr_d      = rr_q;
        diff_d    = diff_q;
        spawn_d   = '0;
        grant     = '0;
        n_grant   = 0;
        last_idx  = 0;
        idx       = 0;

        // A request arriving in the tick cycle itself competes for that tick.
        req_all = pending_q | spawn_req;
        for (int i = 0; i < NUM_COLS; i++) begin
            eligible[i] = req_all[i] && (cd_q[i] == '0);
        end

        // Round-robin scan starting at rr, wrapping, stopping at the cap.
        for (int k = 0; k < NUM_COLS; k++) begin
            idx = (int'(rr_q) + k) % NUM_COLS;
            if (eligible[RR_W'(idx)] && (n_grant < MAX_PER_TICK)) begin
                grant[RR_W'(idx)] = 1'b1;
                n_grant           = n_grant + 1;
                last_idx          = idx;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (game_en) begin
                    state_d   = S_RUN;
                    diff_d    = 3'(DIFF_INIT);
                    pending_d = '0;
                    cnt_d     = '0;
                    rr_d      = '0;
                    for (int i = 0; i < NUM_COLS; i++) begin
                        cd_d[i] = '0;
                    end
                end
            end
            S_RUN: begin
                if (!game_en) begin
                    // Leaving the song wins over a coincident tick.
                    state_d   = S_IDLE;
                    pending_d = '0;
                end else if (tick) begin
                    spawn_d   = grant;
                    pending_d = '0;
                    for (int i = 0; i < NUM_COLS; i++) begin
                        if (grant[i]) begin
                            cd_d[i] = CD_W'(MIN_GAP);
                        end else if (cd_q[i] != '0) begin
                            cd_d[i] = cd_q[i] - CD_W'(1);
                        end
                    end
                    if (n_grant > 0) begin
                        rr_d = RR_W'((last_idx + 1) % NUM_COLS);
                    end
                    if (cnt_q == CNT_W'(RAMP_TICKS - 1)) begin
                        cnt_d = '0;
                        if (diff_q != 3'd7) begin
                            diff_d = diff_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    pending_d = req_all;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            cnt_q     <= '0;
            rr_q      <= '0;
            diff_q    <= 3'(DIFF_INIT);
            spawn_q   <= '0;
            for (int i = 0; i < NUM_COLS; i++) begin
                cd_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            rr_q      <= rr_d;
            diff_q    <= diff_d;
            spawn_q   <= spawn_d;
            for (int i = 0; i < NUM_COLS; i++) begin
                cd_q[i] <= cd_d[i];
            end
        end
    end

    assign spawn_out    = spawn_q;
    assign diff_setting = diff_q;
    assign running      = (state_q == S_RUN);

endmodule

// File: tb/tb_spawn_scheduler.sv
// Testbench for spawn_scheduler: directed vectors, each cycle's expected
// outputs are queued by the stimulus and checked by an independent monitor.
module tb_spawn_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       game_en = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] spawn_req = 4'b0000;
    logic [3:0] spawn_out;
    logic [2:0] diff_setting;
    logic       running;

    spawn_scheduler #(
        .NUM_COLS(4), .MAX_PER_TICK(2), .MIN_GAP(2), .RAMP_TICKS(64), .DIFF_INIT(1)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .game_en(game_en),
        .tick(tick),
        .spawn_req(spawn_req),
        .spawn_out(spawn_out),
        .diff_setting(diff_setting),
        .running(running)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [3:0]  sp;
        logic        run;
        logic [2:0]  diff;
        logic [63:0] nm;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every queued expectation that falls due this cycle.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            n_checks++;
            if (spawn_out !== e.sp) begin
                n_fail++;
                $display("FAIL %0s spawn_out got=%b want=%b cyc=%0d", e.nm, spawn_out, e.sp, cyc);
            end
            n_checks++;
            if (running !== e.run) begin
                n_fail++;
                $display("FAIL %0s running got=%b want=%b cyc=%0d", e.nm, running, e.run, cyc);
            end
            n_checks++;
            if (diff_setting !== e.diff) begin
                n_fail++;
                $display("FAIL %0s diff_setting got=%0d want=%0d cyc=%0d", e.nm, diff_setting, e.diff, cyc);
            end
        end
    end

    // One cycle of stimulus plus the outputs expected after the next edge.
    task automatic step(input logic rs, input logic ge, input logic tk,
                        input logic [3:0] rq, input logic [3:0] es,
                        input logic er, input logic [2:0] ed,
                        input logic [63:0] nm);
        exp_t e;
        @(negedge clk);
        rst_n     = rs;
        game_en   = ge;
        tick      = tk;
        spawn_req = rq;
        e.due  = cyc + 1;
        e.sp   = es;
        e.run  = er;
        e.diff = ed;
        e.nm   = nm;
        exp_q.push_back(e);
    endtask

    initial begin
        // Reset held, then idle requests and ticks are ignored.
        step(0, 0, 0, 4'b0000, 4'b0000, 0, 1, "rst0");
        step(0, 0, 0, 4'b0000, 4'b0000, 0, 1, "rst1");
        step(1, 0, 1, 4'b1111, 4'b0000, 0, 1, "idle0");
        step(1, 0, 1, 4'b1111, 4'b0000, 0, 1, "idle1");
        step(1, 0, 0, 4'b1111, 4'b0000, 0, 1, "idle2");

        // Start; the tick in the starting cycle is ignored.
        step(1, 1, 1, 4'b1111, 4'b0000, 1, 1, "start");
        // Round-robin, back-to-back ticks.
        step(1, 1, 1, 4'b1111, 4'b0011, 1, 1, "rr1");
        step(1, 1, 1, 4'b1111, 4'b1100, 1, 1, "rr2");
        step(1, 1, 1, 4'b1111, 4'b0000, 1, 1, "rr3");
        step(1, 1, 0, 4'b0000, 4'b0000, 1, 1, "gap");

        // Cooldown release for column 0 (rr is 0, all cooldowns now clear
        // except columns 2,3 at 1).
        step(1, 1, 1, 4'b0001, 4'b0001, 1, 1, "cdk");
        step(1, 1, 0, 4'b0000, 4'b0000, 1, 1, "cdg0");
        step(1, 1, 1, 4'b0001, 4'b0000, 1, 1, "cdk1");
        step(1, 1, 0, 4'b0000, 4'b0000, 1, 1, "cdg1");
        step(1, 1, 1, 4'b0001, 4'b0000, 1, 1, "cdk2");
        step(1, 1, 0, 4'b0000, 4'b0000, 1, 1, "cdg2");
        step(1, 1, 1, 4'b0001, 4'b0001, 1, 1, "cdk3");

        // Sticky pending: request five cycles before the tick.
        step(1, 1, 0, 4'b0100, 4'b0000, 1, 1, "stk0");
        for (int i = 0; i < 4; i++) step(1, 1, 0, 4'b0000, 4'b0000, 1, 1, "stkw");
        step(1, 1, 1, 4'b0000, 4'b0100, 1, 1, "stkt");
        step(1, 1, 0, 4'b1000, 4'b0000, 1, 1, "post");
        step(1, 1, 1, 4'b0000, 4'b1000, 1, 1, "postt");

        // Abort on a tick and restart, so the ramp counter begins at 0.
        step(1, 0, 1, 4'b1111, 4'b0000, 0, 1, "abt0");
        step(1, 1, 0, 4'b0000, 4'b0000, 1, 1, "rst2");

        // Difficulty ramp across 448 ticks.
        for (int t = 1; t <= 448; t++) begin
            int d;
            d = 1 + t / 64;
            if (d > 7) d = 7;
            step(1, 1, 1, 4'b0000, 4'b0000, 1, 3'(d), "ramp");
        end

        // Pending request, then abort on a tick: no grant, diff holds.
        step(1, 1, 0, 4'b0010, 4'b0000, 1, 7, "pend");
        step(1, 0, 1, 4'b0001, 4'b0000, 0, 7, "abt1");
        step(1, 0, 0, 4'b0000, 4'b0000, 0, 7, "abt2");
        step(1, 1, 0, 4'b0000, 4'b0000, 1, 1, "rerun");
        step(1, 1, 1, 4'b0000, 4'b0000, 1, 1, "clr");
        step(1, 1, 1, 4'b1111, 4'b0011, 1, 1, "rr0");
        for (int t = 3; t <= 64; t++) begin
            step(1, 1, 1, 4'b0000, 4'b0000, 1, (t == 64) ? 3'd2 : 3'd1, "ramp2");
        end
        step(1, 1, 0, 4'b1111, 4'b0000, 1, 2, "pend2");

        // Reset in the middle of RUN.
        step(0, 1, 1, 4'b1111, 4'b0000, 0, 1, "mrst");
        step(1, 0, 1, 4'b1111, 4'b0000, 0, 1, "mrst1");
        step(1, 1, 1, 4'b1111, 4'b0000, 1, 1, "start2");
        step(1, 1, 1, 4'b1111, 4'b0011, 1, 1, "rrr");
        step(1, 1, 0, 4'b0000, 4'b0000, 1, 1, "end");

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
